// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between EX and a
// 64-bit doubleword-addressed data memory. Computes base + sext(imm),
// performs read-modify-write for sub-doubleword stores, extracts and extends
// load data, and returns a one-cycle response strobe.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses take the error path, no memory access
//   undefined -> misaligned addresses are forced to natural alignment
module load_store_unit #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_base,
    input  logic [11:0] req_imm,
    input  logic [63:0] req_store_data,
    output logic        resp_valid,
    output logic [63:0] resp_load_data,
    output logic        resp_err,
    output logic        mem_En,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [63:0] mem_read_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Read latency as a counter-width constant (legal range 1..4 fits 3 bits)
    localparam logic [2:0] RD_LAT_C = 3'(MEM_RD_LAT);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Low-address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            2'b11:   return 3'b111;
            default: return 3'b111;
        endcase
    endfunction

    // Bit mask covering the access width, right-justified
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            2'b11:   return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Lane-shift the read doubleword and sign/zero-extend per funct3
    function automatic logic [63:0] extend_load(input logic [2:0]  f3,
                                                input logic [63:0] rd,
                                                input logic [2:0]  lane);
        logic [63:0] sh;
        sh = rd >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}},  sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b011:  return sh;
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Replace the addressed lanes of the read doubleword with store bytes
    function automatic logic [63:0] merge_store(input logic [1:0]  size,
                                                input logic [63:0] rd,
                                                input logic [63:0] sd,
                                                input logic [2:0]  lane);
        logic [63:0] m;
        m = size_mask(size) << {lane, 3'b000};
        return (rd & ~m) | ((sd << {lane, 3'b000}) & m);
    endfunction

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [1:0]  state_r;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [2:0]  lane_r;
    logic [63:0] store_data_r;
    logic [2:0]  cnt_r;

    logic        resp_valid_r;
    logic [63:0] resp_load_data_r;
    logic        resp_err_r;
    logic        mem_en_r;
    logic [63:0] mem_address_r;
    logic [63:0] mem_write_data_r;
    logic        mem_rd_r;
    logic        mem_wr_r;

    logic [63:0] eff_addr_s;
    logic [63:0] addr_s;
    logic        illegal_s;
    logic        err_s;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_s;
`endif

    // Decode the incoming request: effective address, legality, alignment
    always_comb begin
        eff_addr_s = req_base + {{52{req_imm[11]}}, req_imm};
        illegal_s  = (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = (eff_addr_s[2:0] & align_mask(req_funct3[1:0])) != 3'b000;
        addr_s     = eff_addr_s;
        err_s      = illegal_s || misalign_s;
`else
        addr_s     = {eff_addr_s[63:3], eff_addr_s[2:0] & ~align_mask(req_funct3[1:0])};
        err_s      = illegal_s;
`endif
    end

    // Request FSM with registered memory and response outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r          <= ST_IDLE;
            is_store_r       <= 1'b0;
            funct3_r         <= 3'b000;
            lane_r           <= 3'b000;
            store_data_r     <= 64'd0;
            cnt_r            <= 3'd0;
            resp_valid_r     <= 1'b0;
            resp_load_data_r <= 64'd0;
            resp_err_r       <= 1'b0;
            mem_en_r         <= 1'b0;
            mem_address_r    <= 64'd0;
            mem_write_data_r <= 64'd0;
            mem_rd_r         <= 1'b0;
            mem_wr_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_store_r   <= req_is_store;
                        funct3_r     <= req_funct3;
                        lane_r       <= addr_s[2:0];
                        store_data_r <= req_store_data;
                        cnt_r        <= 3'd1;
                        if (err_s) begin
                            // Illegal or trapped request: respond without touching memory
                            state_r          <= ST_RESP;
                            resp_valid_r     <= 1'b1;
                            resp_err_r       <= 1'b1;
                            resp_load_data_r <= 64'd0;
                        end else if (req_is_store && (req_funct3[1:0] == 2'b11)) begin
                            // Full doubleword store needs no merge read
                            state_r          <= ST_WR;
                            mem_en_r         <= 1'b1;
                            mem_wr_r         <= 1'b1;
                            mem_address_r    <= {3'b000, addr_s[63:3]};
                            mem_write_data_r <= req_store_data;
                        end else begin
                            // Loads and partial stores both start with a read
                            state_r       <= ST_RD;
                            mem_en_r      <= 1'b1;
                            mem_rd_r      <= 1'b1;
                            mem_address_r <= {3'b000, addr_s[63:3]};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (cnt_r == RD_LAT_C) begin
                        mem_rd_r <= 1'b0;
                        if (is_store_r) begin
                            // Read data arrives now: write back the merged doubleword
                            state_r          <= ST_WR;
                            mem_en_r         <= 1'b1;
                            mem_wr_r         <= 1'b1;
                            mem_write_data_r <= merge_store(funct3_r[1:0], mem_read_data,
                                                            store_data_r, lane_r);
                        end else begin
                            state_r          <= ST_RESP;
                            mem_en_r         <= 1'b0;
                            mem_address_r    <= 64'd0;
                            resp_valid_r     <= 1'b1;
                            resp_err_r       <= 1'b0;
                            resp_load_data_r <= extend_load(funct3_r, mem_read_data, lane_r);
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_WR: begin
                    state_r          <= ST_RESP;
                    mem_en_r         <= 1'b0;
                    mem_wr_r         <= 1'b0;
                    mem_address_r    <= 64'd0;
                    mem_write_data_r <= 64'd0;
                    resp_valid_r     <= 1'b1;
                    resp_err_r       <= 1'b0;
                    resp_load_data_r <= 64'd0;
                end
                ST_RESP: begin
                    state_r          <= ST_IDLE;
                    resp_valid_r     <= 1'b0;
                    resp_err_r       <= 1'b0;
                    resp_load_data_r <= 64'd0;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    resp_valid_r     <= 1'b0;
                    resp_err_r       <= 1'b0;
                    resp_load_data_r <= 64'd0;
                    mem_en_r         <= 1'b0;
                    mem_rd_r         <= 1'b0;
                    mem_wr_r         <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = (state_r == ST_IDLE);
    assign resp_valid     = resp_valid_r;
    assign resp_load_data = resp_load_data_r;
    assign resp_err       = resp_err_r;
    assign mem_En         = mem_en_r;
    assign mem_address    = mem_address_r;
    assign mem_write_data = mem_write_data_r;
    assign mem_memRead    = mem_rd_r;
    assign mem_memWrite   = mem_wr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a combinational (latency 1)
// doubleword memory model. Expected values are hand-computed constants.
module tb_load_store_unit;

    logic        Clk;
    logic        Rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_base;
    logic [11:0] req_imm;
    logic [63:0] req_store_data;
    logic        resp_valid;
    logic [63:0] resp_load_data;
    logic        resp_err;
    logic        mem_En;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [63:0] mem_read_data;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mem_model [0:15];
    int rd_cnt = 0, wr_cnt = 0, en_cnt = 0, resp_cnt = 0, both_cnt = 0, en_bad = 0;
    logic [63:0] last_wr_addr = 64'd0;

    int d_rd, d_wr, d_en;

    load_store_unit #(.MEM_RD_LAT(1)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_imm(req_imm), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_err(resp_err),
        .mem_En(mem_En), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_read_data(mem_read_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_read_data = mem_memRead ? mem_model[mem_address[3:0]] : 64'd0;

    // Memory write and bus activity bookkeeping
    always @(posedge Clk) begin
        if (mem_En && mem_memWrite) mem_model[mem_address[3:0]] <= mem_write_data;
        if (mem_memRead)  rd_cnt <= rd_cnt + 1;
        if (mem_memWrite) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_address;
        end
        if (mem_En)     en_cnt   <= en_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (mem_memRead && mem_memWrite) both_cnt <= both_cnt + 1;
        if (mem_En !== (mem_memRead | mem_memWrite)) en_bad <= en_bad + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its response, record bus deltas
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [63:0] base,
                           input logic [11:0] imm, input logic [63:0] sd,
                           output logic [63:0] d, output logic e, output int lat);
        int rd0, wr0, en0;
        rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cnt;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_base = base; req_imm = imm; req_store_data = sd;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        lat = -1; d = 64'd0; e = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid) begin
                lat = k; d = resp_load_data; e = resp_err;
                break;
            end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
        d_rd = rd_cnt - rd0; d_wr = wr_cnt - wr0; d_en = en_cnt - en0;
    endtask

    task automatic expect_req(input string tag, input logic st, input logic [2:0] f3,
                              input logic [63:0] base, input logic [11:0] imm,
                              input logic [63:0] sd, input logic [63:0] exp_d,
                              input logic exp_e, input int exp_lat,
                              input int exp_rd, input int exp_wr);
        logic [63:0] d;
        logic        e;
        int          lat;
        run_req(st, f3, base, imm, sd, d, e, lat);
        check_val({tag, "_data"}, d, exp_d);
        check_val({tag, "_err"}, 64'(e), 64'(exp_e));
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_rd"}, 64'(d_rd), 64'(exp_rd));
        check_val({tag, "_wr"}, 64'(d_wr), 64'(exp_wr));
        check_val({tag, "_en"}, 64'(d_en), 64'(exp_rd + exp_wr));
        check_val({tag, "_resp_clr"}, {63'd0, resp_valid}, 64'd0);
        check_val({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int r0;
        Rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_base = 64'd0; req_imm = 12'd0; req_store_data = 64'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_val("rst_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_val("rst_mem_en", {63'd0, mem_En}, 64'd0);
        check_val("rst_resp_data", resp_load_data, 64'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // SD then LD of the same doubleword
        expect_req("sd_258", 1'b1, 3'b011, 64'd0, 12'd8, 64'd258, 64'd0, 1'b0, 1, 0, 1);
        check_val("sd_addr", last_wr_addr, 64'd1);
        expect_req("ld_258", 1'b0, 3'b011, 64'd8, 12'd0, 64'd0, 64'd258, 1'b0, 1, 1, 0);

        // Byte store read-modify-write into an all-ones doubleword
        expect_req("sd_ones", 1'b1, 3'b011, 64'd8, 12'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1, 0, 1);
        expect_req("sb_12", 1'b1, 3'b000, 64'd9, 12'd0, 64'h12, 64'd0, 1'b0, 2, 1, 1);
        expect_req("ld_rmw", 1'b0, 3'b011, 64'd8, 12'd0, 64'd0, 64'hFFFF_FFFF_FFFF_12FF, 1'b0, 1, 1, 0);

        // Negative offset byte store, then signed/unsigned byte and half loads
        expect_req("sb_80", 1'b1, 3'b000, 64'd16, 12'hFF9, 64'hAB80, 64'd0, 1'b0, 2, 1, 1);
        expect_req("lb_80", 1'b0, 3'b000, 64'd9, 12'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 1, 0);
        expect_req("lbu_80", 1'b0, 3'b100, 64'd9, 12'd0, 64'd0, 64'h80, 1'b0, 1, 1, 0);
        expect_req("lh_80ff", 1'b0, 3'b001, 64'd8, 12'd0, 64'd0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 1, 1, 0);

        // Lane extraction on a patterned doubleword
        expect_req("sd_pat", 1'b1, 3'b011, 64'd0, 12'd0, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1, 0, 1);
        expect_req("lwu_l4", 1'b0, 3'b110, 64'd12, 12'hFF8, 64'd0, 64'h1122_3344, 1'b0, 1, 1, 0);
        expect_req("lhu_l6", 1'b0, 3'b101, 64'd6, 12'd0, 64'd0, 64'h1122, 1'b0, 1, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        expect_req("lw_mis", 1'b0, 3'b010, 64'd2, 12'd0, 64'd0, 64'd0, 1'b1, 0, 0, 0);
`else
        expect_req("lw_mis", 1'b0, 3'b010, 64'd2, 12'd0, 64'd0, 64'h5566_7788, 1'b0, 1, 1, 0);
`endif

        // Illegal funct3 codes
        expect_req("ill_111", 1'b0, 3'b111, 64'd8, 12'd0, 64'd0, 64'd0, 1'b1, 0, 0, 0);
        expect_req("ill_sb100", 1'b1, 3'b100, 64'd8, 12'd0, 64'h55, 64'd0, 1'b1, 0, 0, 0);
        expect_req("ld_after_ill", 1'b0, 3'b011, 64'd8, 12'd0, 64'd0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 1, 1, 0);

        // req_valid held high through a load is ignored until ready returns
        r0 = rd_cnt;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011;
        req_base = 64'd0; req_imm = 12'd0;
        @(posedge Clk); #1;
        check_val("hold_busy_ready", {63'd0, req_ready}, 64'd0);
        @(posedge Clk); #1;
        check_val("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
        check_val("hold_resp_data", resp_load_data, 64'h1122_3344_5566_7788);
        @(posedge Clk); #1;
        check_val("hold_ready_back", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b0;
        @(posedge Clk); #1;
        check_val("hold_reads", 64'(rd_cnt - r0), 64'd1);

        // Reset while a load is in the RD state
        r0 = resp_cnt;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011;
        req_base = 64'd8; req_imm = 12'd0;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        check_val("mid_rd_active", {63'd0, mem_memRead}, 64'd1);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        check_val("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        check_val("mid_rst_mem", {61'd0, mem_En, mem_memRead, mem_memWrite}, 64'd0);
        check_val("mid_rst_addr", mem_address, 64'd0);
        repeat (4) @(posedge Clk);
        #1;
        check_val("mid_rst_noresp", 64'(resp_cnt - r0), 64'd0);

        check_val("rd_wr_exclusive", 64'(both_cnt), 64'd0);
        check_val("en_is_or", 64'(en_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
